vga_timing_ctrl: RTL

//   Raster timing controller for the 640x480@60 VGA path. Derives a pixel-rate enable, runs the

---
 rtl/vga_timing_ctrl_pkg.sv | 30 +++
 rtl/vga_axis_timing.sv | 71 +++++++
 rtl/vga_timing_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vga_timing_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | vga_timing_ctrl_pkg                                                        |
// | Default 640x480@60 raster constants, shared with the colour generator.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package vga_timing_ctrl_pkg;

  localparam int C_CNT_W   = 10;
  localparam int C_MAX_CNT = 1 << C_CNT_W;

  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;

  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 33;
  localparam int C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;

  // Level driven on hsync/vsync inside the pulse window.
  localparam logic C_SYNC_ACTIVE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/vga_axis_timing.sv
// +----------------------------------------------------------------------------+
// | vga_axis_timing                                                            |
// | One raster axis: enabled wrap counter with registered active/sync decode. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_axis_timing
  import vga_timing_ctrl_pkg::*;
#(
  parameter int ACTIVE = C_H_ACTIVE,
  parameter int FP     = C_H_FP,
  parameter int SYNC   = C_H_SYNC,
  parameter int BP     = C_H_BP
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_sclr,
  input  logic               i_en,
  output logic [C_CNT_W-1:0] o_cnt,
  output logic               o_active,
  output logic               o_sync_n,
  output logic               o_wrap
);

  localparam int c_total = ACTIVE + FP + SYNC + BP;
  localparam logic [C_CNT_W-1:0] c_last    = C_CNT_W'(c_total - 1);
  localparam logic [C_CNT_W:0]   c_active  = (C_CNT_W + 1)'(ACTIVE);
  localparam logic [C_CNT_W:0]   c_sync_lo = (C_CNT_W + 1)'(ACTIVE + FP);
  localparam logic [C_CNT_W:0]   c_sync_hi = (C_CNT_W + 1)'(ACTIVE + FP + SYNC);

  if (c_total > C_MAX_CNT) begin : g_total_chk
    $error("vga_axis_timing: axis total %0d exceeds counter range %0d", c_total, C_MAX_CNT);
  end

  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic [C_CNT_W:0]   w_cnt_x;
  logic               w_in_sync;

  assign o_wrap = (o_cnt == c_last);

  always_comb begin
    w_cnt_nxt = o_cnt;
    if (i_en) begin
      w_cnt_nxt = o_wrap ? '0 : o_cnt + 1'b1;
    end
  end

  // Decode uses one extra bit so a window ending exactly at 1024 still compares correctly.
  assign w_cnt_x   = {1'b0, w_cnt_nxt};
  assign w_in_sync = (w_cnt_x >= c_sync_lo) && (w_cnt_x < c_sync_hi);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt    <= c_last;
      o_active <= 1'b0;
      o_sync_n <= ~C_SYNC_ACTIVE;
    end else if (i_sclr) begin
      o_cnt    <= c_last;
      o_active <= 1'b0;
      o_sync_n <= ~C_SYNC_ACTIVE;
    end else begin
      o_cnt    <= w_cnt_nxt;
      o_active <= (w_cnt_x < c_active);
      o_sync_n <= w_in_sync ? C_SYNC_ACTIVE : ~C_SYNC_ACTIVE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// +----------------------------------------------------------------------------+
// | vga_timing_ctrl                                                            |
// | VGA raster timing: pixel enable, h/v counters, syncs, enables, indices.   |
// | Option VGA_EXT_PXCLK_EN: pixel enable taken from i_px_clk, no prescaler.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int PX_DIV   = 4,
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_sclr,
`ifdef VGA_EXT_PXCLK_EN
  input  logic               i_px_clk,
`endif
  output logic               o_px_en,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_haddr_en,
  output logic               o_vaddr_en,
  output logic [C_CNT_W-1:0] o_hidx,
  output logic [C_CNT_W-1:0] o_vidx,
  output logic               o_line_start,
  output logic               o_frame_start
);

  if (PX_DIV < 1 || PX_DIV > 16) begin : g_div_chk
    $error("vga_timing_ctrl: PX_DIV %0d outside 1..16", PX_DIV);
  end

  logic w_px_en;
  logic w_h_wrap;
  logic w_v_wrap;
  logic r_line_start;
  logic r_frame_start;

`ifdef VGA_EXT_PXCLK_EN
  assign w_px_en = i_px_clk;
`else
  localparam int c_pw = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;
  localparam logic [c_pw-1:0] c_pmax = c_pw'(PX_DIV - 1);

  logic [c_pw-1:0] r_pcnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pcnt <= '0;
    end else if (i_sclr) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= (r_pcnt == c_pmax) ? '0 : r_pcnt + 1'b1;
    end
  end

  // With PX_DIV=1 the counter is pinned at 0 == c_pmax, so the enable is constant 1.
  assign w_px_en = (r_pcnt == c_pmax);
`endif

  vga_axis_timing #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_sclr   (i_sclr),
    .i_en     (w_px_en),
    .o_cnt    (o_hidx),
    .o_active (o_haddr_en),
    .o_sync_n (o_hsync),
    .o_wrap   (w_h_wrap)
  );

  vga_axis_timing #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_sclr   (i_sclr),
    .i_en     (w_px_en & w_h_wrap),
    .o_cnt    (o_vidx),
    .o_active (o_vaddr_en),
    .o_sync_n (o_vsync),
    .o_wrap   (w_v_wrap)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (i_sclr) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_px_en & w_h_wrap;
      r_frame_start <= w_px_en & w_h_wrap & w_v_wrap;
    end
  end

  assign o_px_en       = w_px_en;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

`default_nettype wire
